// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate lab checkers: FSM state codes and the
// standard 2-input truth tables, each indexed by {a,b}.
package gate_check_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_VEC = 3'd1;
  localparam logic [2:0] SETTLE   = 3'd2;
  localparam logic [2:0] COMPARE  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  function automatic logic tt_lookup(input logic [3:0] tt, input logic a, input logic b);
    return tt[{a, b}];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// 8-bit loadable down-counter. expired is high on the last counting cycle,
// so a loaded value of N keeps the caller in its wait state for exactly N cycles.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && count_q != 8'd0) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign expired = (count_q <= 8'd1);

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate: accepts a/b vectors, waits a settle
// time, compares dut_out against TRUTH_TABLE and reports pass/fail per run.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_VECTORS   = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_a,
  input  logic             vec_b,
  output logic             vec_ready,
  input  logic             dut_out,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             done,
  output logic             pass
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [7:0] NUM_VEC8    = 8'(NUM_VECTORS);

  logic [2:0]       state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic [7:0]       vec_cnt_q, vec_cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             mismatch_q, mismatch_d;
  logic             timer_load, timer_en, timer_expired;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (SETTLE_LOAD),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    vec_cnt_d  = vec_cnt_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_d     = '0;
          vec_cnt_d = 8'd0;
          state_d   = WAIT_VEC;
        end
      end
      WAIT_VEC: begin
        if (vec_valid) begin
          a_d        = vec_a;
          b_d        = vec_b;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        timer_en = 1'b1;
        if (timer_expired) state_d = COMPARE;
      end
      COMPARE: begin
        // Compare against the latched vector; live a/b may already have moved on.
        if (dut_out != tt_lookup(TRUTH_TABLE, a_q, b_q)) begin
          mismatch_d = 1'b1;
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
        end
        vec_cnt_d = vec_cnt_q + 8'd1;
        state_d   = (vec_cnt_d == NUM_VEC8) ? DONE : WAIT_VEC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      vec_cnt_q  <= 8'd0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      vec_cnt_q  <= vec_cnt_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign vec_ready = (state_q == WAIT_VEC);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign mismatch  = mismatch_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: a default AND checker and a narrow-counter
// variant (ERR_W=2, NUM_VECTORS=6) share one stimulus driver selected by sel.
module tb_gate_response_checker;

  localparam int S = 2;

  typedef struct {
    bit a;
    bit b;
    bit resp;
    bit scr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sel = 1'b0;
  logic v_start = 1'b0, v_valid = 1'b0, v_a = 1'b0, v_b = 1'b0, v_resp = 1'b0;

  logic start0, valid0, ready0, mis0, done0, pass0;
  logic [7:0] err0;
  logic start1, valid1, ready1, mis1, done1, pass1;
  logic [1:0] err1;

  logic ready, mis, done, pass;
  logic [7:0] err;

  assign start0 = !sel && v_start;
  assign valid0 = !sel && v_valid;
  assign start1 = sel && v_start;
  assign valid1 = sel && v_valid;
  assign ready  = sel ? ready1 : ready0;
  assign mis    = sel ? mis1 : mis0;
  assign done   = sel ? done1 : done0;
  assign pass   = sel ? pass1 : pass0;
  assign err    = sel ? {6'd0, err1} : err0;

  gate_response_checker u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_valid(valid0), .vec_a(v_a), .vec_b(v_b),
    .vec_ready(ready0), .dut_out(v_resp), .mismatch(mis0), .err_count(err0),
    .done(done0), .pass(pass0)
  );

  gate_response_checker #(.ERR_W(2), .NUM_VECTORS(6)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_valid(valid1), .vec_a(v_a), .vec_b(v_b),
    .vec_ready(ready1), .dut_out(v_resp), .mismatch(mis1), .err_count(err1),
    .done(done1), .pass(pass1)
  );

  int n_vec = 0;
  int n_mis = 0;
  int model_err = 0;
  int model_cnt = 0;
  int err_max = 255;
  int num_vec = 4;
  vec_t tbl[18];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_mismatch"}, mis, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
  endtask

  task automatic do_start(input bit with_valid);
    v_start = 1'b1;
    v_valid = with_valid;
    tick;
    v_start = 1'b0;
    v_valid = 1'b0;
    model_err = 0;
    model_cnt = 0;
    check("start_ready", ready, 1);
    check("start_err", err, 0);
    check("start_done", done, 0);
    check("start_pass", pass, 0);
    $display("start: sel=%0d ready=%0d err=%0d", sel, ready, err);
  endtask

  // One transaction: present, wait for accept, settle, then check the result.
  task automatic send_vec(input bit a, input bit b, input bit resp, input bit scr);
    int guard;
    bit exp_mis;
    guard = 0;
    v_a = a; v_b = b; v_resp = resp; v_valid = 1'b1;
    while (ready !== 1'b1 && guard < 50) begin
      tick;
      guard++;
    end
    if (guard >= 50) begin
      check("ready_timeout", 0, 1);
      v_valid = 1'b0;
      return;
    end
    tick;
    for (int i = 0; i <= S; i++) begin
      if (scr && i < S) begin
        v_a = 1'($urandom);
        v_b = 1'($urandom);
      end else begin
        v_valid = 1'b0;
      end
      tick;
      if (i < S) begin
        check("settle_mismatch", mis, 0);
        check("settle_ready", ready, 0);
      end
    end
    exp_mis = (resp != (a & b));
    if (exp_mis && model_err < err_max) model_err++;
    model_cnt++;
    check("mismatch", mis, int'(exp_mis));
    check("err_count", err, model_err);
    check("done", done, int'(model_cnt == num_vec));
    check("pass", pass, int'(model_cnt == num_vec && model_err == 0));
    check("ready_after", ready, int'(model_cnt != num_vec));
    $display("vec: sel=%0d a=%0d b=%0d resp=%0d scr=%0d mismatch=%0d err=%0d done=%0d pass=%0d",
             sel, a, b, resp, scr, mis, err, done, pass);
    tick;
    check("mismatch_pulse", mis, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 0, 0, 0}; tbl[1]  = '{0, 1, 0, 0}; tbl[2]  = '{1, 0, 0, 0}; tbl[3]  = '{1, 1, 1, 0};
    tbl[4]  = '{0, 0, 0, 0}; tbl[5]  = '{0, 1, 1, 0}; tbl[6]  = '{1, 0, 1, 0}; tbl[7]  = '{1, 1, 1, 0};
    tbl[8]  = '{1, 1, 1, 1}; tbl[9]  = '{0, 1, 0, 1}; tbl[10] = '{1, 1, 0, 1}; tbl[11] = '{0, 0, 0, 1};
    tbl[12] = '{0, 0, 1, 0}; tbl[13] = '{0, 1, 1, 0}; tbl[14] = '{1, 0, 1, 0}; tbl[15] = '{1, 1, 1, 0};
    tbl[16] = '{0, 0, 1, 0}; tbl[17] = '{0, 1, 1, 0};

    rst = 1'b1;
    tick; tick;
    check_idle("reset");
    rst = 1'b0;
    tick;
    check_idle("idle");

    // Correct AND gate; start arrives together with a vector that must be ignored.
    do_start(1'b1);
    for (int i = 0; i < 4; i++) send_vec(tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].scr);
    // OR gate wired in.
    do_start(1'b0);
    for (int i = 4; i < 8; i++) send_vec(tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].scr);
    // Inputs keep changing during settle; only the accepted vector counts.
    do_start(1'b0);
    for (int i = 8; i < 12; i++) send_vec(tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].scr);

    for (int r = 0; r < 3; r++) begin
      do_start(1'b0);
      for (int i = 0; i < 4; i++)
        send_vec(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset during the settle of vector 3 discards the partial run.
    do_start(1'b0);
    send_vec(0, 1, 1, 0);
    send_vec(1, 1, 1, 0);
    v_a = 1'b1; v_b = 1'b0; v_resp = 1'b1; v_valid = 1'b1;
    for (int g = 0; g < 50 && ready !== 1'b1; g++) tick;
    check("rst_accept_ready", ready, 1);
    tick;
    v_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_idle("rst_mid");
    $display("rst mid-run: ready=%0d err=%0d done=%0d", ready, err, done);
    tick;
    check_idle("rst_after");
    do_start(1'b0);
    send_vec(1, 0, 1, 0);
    send_vec(0, 0, 0, 0);
    send_vec(1, 1, 1, 0);
    send_vec(0, 1, 0, 0);

    // Narrow counter with a stuck-at-1 DUT saturates at 3.
    sel = 1'b1;
    err_max = 3;
    num_vec = 6;
    do_start(1'b0);
    for (int i = 12; i < 18; i++) send_vec(tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].scr);
    check("sat_err", err, 3);
    do_start(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
